// File: rtl/fpu_arbiter_if.sv
// Bundle of requester, FPU-side and response signals for fpu_arbiter.
// The slave modport is the arbiter. The master modport is everything around it:
// the two requesters, the FPU instance and the response consumer.
interface fpu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic        req0_op;
    logic        req0_type;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic        req1_op;
    logic        req1_type;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        fpu_control;
    logic        fpu_float_type;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [31:0] fpu_result;
    logic [3:0]  fpu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;
    logic [15:0] op_count;

    modport slave (
        input  req0_valid, req0_op, req0_type, req0_a, req0_b,
        input  req1_valid, req1_op, req1_type, req1_a, req1_b,
        input  fpu_result, fpu_flags, rsp_ready,
        output req0_ready, req1_ready,
        output fpu_control, fpu_float_type, fpu_a, fpu_b,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, busy, op_count
    );

    modport master (
        output req0_valid, req0_op, req0_type, req0_a, req0_b,
        output req1_valid, req1_op, req1_type, req1_a, req1_b,
        output fpu_result, fpu_flags, rsp_ready,
        input  req0_ready, req1_ready,
        input  fpu_control, fpu_float_type, fpu_a, fpu_b,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, busy, op_count
    );
endinterface

// File: rtl/fpu_arbiter.sv
// Two-way round-robin sequencer in front of one shared combinational FPU.
// It accepts one operation and registers its operands onto the FPU inputs.
// It then waits LATENCY settle cycles, captures the FPU result and flags, and
// presents them on the response channel tagged with the requester ID.
module fpu_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    fpu_arbiter_if.slave bus
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range
        $error("fpu_arbiter: LATENCY must be within 1..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        logic        op;
        logic        float_type;
        logic [31:0] a;
        logic [31:0] b;
    } fpu_req_t;

    state_t      state;
    state_t      state_next;
    fpu_req_t    req_sel;
    fpu_req_t    fpu_q;
    logic        grant_any;
    logic        grant_id;
    logic        accept;
    logic        capture;
    logic        retire;
    logic        last_grant;
    logic [3:0]  cnt;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [15:0] op_count;

    // Arbitration, handshake decode and next-state selection.
    always_comb begin
        // NOTE: every signal written here is given a default first, so no path leaves one unassigned and no latch is inferred.
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        grant_any  = bus.req0_valid | bus.req1_valid;
        // Under contention the requester that did not win last time is granted.
        grant_id   = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
        req_sel    = grant_id ? {bus.req1_op, bus.req1_type, bus.req1_a, bus.req1_b}
                              : {bus.req0_op, bus.req0_type, bus.req0_a, bus.req0_b};
        case (state)
            IDLE: begin
                // Reset masks the grant so that no handshake completes on a reset edge.
                if (grant_any && !reset) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every flop samples the pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Operand, settle-counter, response and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpu_q      <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                fpu_q      <= req_sel;
                rsp_id     <= grant_id;
                last_grant <= grant_id;
                cnt        <= CNT_LOAD;
            end
            if (capture) begin
                rsp_result <= bus.fpu_result;
                rsp_flags  <= bus.fpu_flags;
            end else if (state == EXEC) begin
                cnt <= cnt - 4'd1;
            end
            if (retire) op_count <= op_count + 16'd1;
        end
    end

    assign bus.req0_ready     = accept & ~grant_id;
    assign bus.req1_ready     = accept & grant_id;
    assign bus.fpu_control    = fpu_q.op;
    assign bus.fpu_float_type = fpu_q.float_type;
    assign bus.fpu_a          = fpu_q.a;
    assign bus.fpu_b          = fpu_q.b;
    assign bus.rsp_valid      = (state == RESP);
    assign bus.rsp_id         = rsp_id;
    assign bus.rsp_result     = rsp_result;
    assign bus.rsp_flags      = rsp_flags;
    assign bus.busy           = (state != IDLE);
    assign bus.op_count       = op_count;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter. It runs two instances: LATENCY = 2 and LATENCY = 1.
// A stand-in FPU function drives each instance's FPU result.
// A transaction-level model predicts every output on every cycle.
// Directed scenarios add literal expectations at the interesting points.
module tb_fpu_arbiter;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    typedef struct {
        logic        valid;
        logic        op;
        logic        ty;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct {
        logic        rdy0, rdy1, fctl, fty, rv, rid, busy;
        logic [31:0] fa, fb, rres;
        logic [3:0]  rfl;
        logic [15:0] cnt;
    } obs_t;

    typedef struct {
        bit          in_flight, have_rsp, last_id, rid, fctl, fty;
        int          age;
        logic [31:0] fa, fb, rres;
        logic [3:0]  rfl;
        logic [15:0] count;
    } model_t;

    logic   clk = 1'b0;
    logic   rst [2];
    logic   rsp_ready [2];
    req_t   req [2][2];
    obs_t   obs0, obs1;
    model_t m [2];
    int     acc_q0[$];
    int     acc_q1[$];
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Stand-in FPU: exact results for the documented vectors, a mixing function otherwise.
    function automatic logic [35:0] fpu_fn(input logic op, input logic ty,
                                           input logic [31:0] a, input logic [31:0] b);
        if (op && ty && a == 32'h40E00000 && b == 32'h40200000) return {4'h0, 32'h418C0000};
        if (!op && ty && a == 32'h40E00000 && b == 32'h40200000) return {4'h0, 32'h41180000};
        if (op && !ty && a == 32'h00004700 && b == 32'h00004100) return {4'h0, 32'h00004C60};
        return {a[3:0] ^ b[7:4] ^ {2'b00, op, ty}, a ^ {b[15:0], b[31:16]} ^ {30'd0, op, ty}};
    endfunction

    fpu_arbiter_if bus0 ();
    fpu_arbiter_if bus1 ();

    fpu_arbiter #(.LATENCY(LAT0)) dut0 (.clk(clk), .reset(rst[0]), .bus(bus0.slave));
    fpu_arbiter #(.LATENCY(LAT1)) dut1 (.clk(clk), .reset(rst[1]), .bus(bus1.slave));

    assign bus0.req0_valid = req[0][0].valid;
    assign bus0.req0_op    = req[0][0].op;
    assign bus0.req0_type  = req[0][0].ty;
    assign bus0.req0_a     = req[0][0].a;
    assign bus0.req0_b     = req[0][0].b;
    assign bus0.req1_valid = req[0][1].valid;
    assign bus0.req1_op    = req[0][1].op;
    assign bus0.req1_type  = req[0][1].ty;
    assign bus0.req1_a     = req[0][1].a;
    assign bus0.req1_b     = req[0][1].b;
    assign bus0.rsp_ready  = rsp_ready[0];
    assign {bus0.fpu_flags, bus0.fpu_result} =
        fpu_fn(bus0.fpu_control, bus0.fpu_float_type, bus0.fpu_a, bus0.fpu_b);

    assign bus1.req0_valid = req[1][0].valid;
    assign bus1.req0_op    = req[1][0].op;
    assign bus1.req0_type  = req[1][0].ty;
    assign bus1.req0_a     = req[1][0].a;
    assign bus1.req0_b     = req[1][0].b;
    assign bus1.req1_valid = req[1][1].valid;
    assign bus1.req1_op    = req[1][1].op;
    assign bus1.req1_type  = req[1][1].ty;
    assign bus1.req1_a     = req[1][1].a;
    assign bus1.req1_b     = req[1][1].b;
    assign bus1.rsp_ready  = rsp_ready[1];
    assign {bus1.fpu_flags, bus1.fpu_result} =
        fpu_fn(bus1.fpu_control, bus1.fpu_float_type, bus1.fpu_a, bus1.fpu_b);

    always_comb begin
        obs0.rdy0 = bus0.req0_ready;   obs0.rdy1 = bus0.req1_ready;
        obs0.fctl = bus0.fpu_control;  obs0.fty  = bus0.fpu_float_type;
        obs0.fa   = bus0.fpu_a;        obs0.fb   = bus0.fpu_b;
        obs0.rv   = bus0.rsp_valid;    obs0.rid  = bus0.rsp_id;
        obs0.rres = bus0.rsp_result;   obs0.rfl  = bus0.rsp_flags;
        obs0.busy = bus0.busy;         obs0.cnt  = bus0.op_count;
        obs1.rdy0 = bus1.req0_ready;   obs1.rdy1 = bus1.req1_ready;
        obs1.fctl = bus1.fpu_control;  obs1.fty  = bus1.fpu_float_type;
        obs1.fa   = bus1.fpu_a;        obs1.fb   = bus1.fpu_b;
        obs1.rv   = bus1.rsp_valid;    obs1.rid  = bus1.rsp_id;
        obs1.rres = bus1.rsp_result;   obs1.rfl  = bus1.rsp_flags;
        obs1.busy = bus1.busy;         obs1.cnt  = bus1.op_count;
    end

    function automatic obs_t get_obs(input int d);
        if (d == 0) return obs0;
        return obs1;
    endfunction

    function automatic model_t reset_model();
        model_t s;
        s = '{default: 0};
        s.last_id = 1'b1;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin : per_dut
            obs_t   o;
            model_t s;
            req_t   r0, r1, rg;
            bit     any, id, idle;
            string  p;
            o    = get_obs(d);
            s    = m[d];
            r0   = req[d][0];
            r1   = req[d][1];
            p    = $sformatf("dut%0d.", d);
            any  = r0.valid | r1.valid;
            id   = (r0.valid && r1.valid) ? !s.last_id : r1.valid;
            idle = !s.in_flight && !s.have_rsp;
            check({p, "req0_ready"}, o.rdy0, !rst[d] && idle && any && !id);
            check({p, "req1_ready"}, o.rdy1, !rst[d] && idle && any && id);
            check({p, "busy"},       o.busy, !idle);
            check({p, "rsp_valid"},  o.rv,   s.have_rsp);
            check({p, "rsp_id"},     o.rid,  s.rid);
            check({p, "rsp_result"}, o.rres, s.rres);
            check({p, "rsp_flags"},  o.rfl,  s.rfl);
            check({p, "fpu_ctl"},    o.fctl, s.fctl);
            check({p, "fpu_type"},   o.fty,  s.fty);
            check({p, "fpu_a"},      o.fa,   s.fa);
            check({p, "fpu_b"},      o.fb,   s.fb);
            check({p, "op_count"},   o.cnt,  s.count);
            if (rst[d]) begin
                s = reset_model();
            end else if (s.have_rsp) begin
                if (rsp_ready[d]) begin
                    s.have_rsp = 1'b0;
                    s.count    = s.count + 16'd1;
                end
            end else if (s.in_flight) begin
                s.age++;
                if (s.age == ((d == 0) ? LAT0 : LAT1)) begin
                    {s.rfl, s.rres} = fpu_fn(s.fctl, s.fty, s.fa, s.fb);
                    s.have_rsp  = 1'b1;
                    s.in_flight = 1'b0;
                end
            end else if (any) begin
                rg          = id ? r1 : r0;
                s.fctl      = rg.op;
                s.fty       = rg.ty;
                s.fa        = rg.a;
                s.fb        = rg.b;
                s.rid       = id;
                s.last_id   = id;
                s.in_flight = 1'b1;
                s.age       = 0;
                if (d == 0) acc_q0.push_back(cyc * 2 + int'(id));
                else        acc_q1.push_back(cyc * 2 + int'(id));
            end
            m[d] = s;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int d, input int max_cycles);
        obs_t o;
        int   n = 0;
        o = get_obs(d);
        while (o.busy && n < max_cycles) begin
            tick();
            n++;
            o = get_obs(d);
        end
        check($sformatf("dut%0d.drain_busy", d), o.busy, 1'b0);
    endtask

    initial begin
        obs_t o;
        obs_t saved;
        m[0] = reset_model();
        m[1] = reset_model();
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            rsp_ready[d] = 1'b1;
            for (int k = 0; k < 2; k++) req[d][k] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        end
        tick(2);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        o = get_obs(0);
        check("reset.busy", o.busy, 1'b0);
        check("reset.op_count", o.cnt, 16'h0000);

        // Single-precision multiply from requester 0, LATENCY = 2.
        req[0][0] = '{1'b1, 1'b1, 1'b1, 32'h40E00000, 32'h40200000};
        #1;
        o = get_obs(0);
        check("mul.req0_ready", o.rdy0, 1'b1);
        tick();
        req[0][0].valid = 1'b0;
        req[0][0].a     = 32'hFFFFFFFF;
        o = get_obs(0);
        check("mul.rv_after_e0", o.rv, 1'b0);
        tick();
        o = get_obs(0);
        check("mul.rv_after_e1", o.rv, 1'b0);
        tick();
        o = get_obs(0);
        check("mul.rv_after_e2", o.rv, 1'b1);
        check("mul.rsp_id", o.rid, 1'b0);
        check("mul.rsp_result", o.rres, 32'h418C0000);
        tick();
        o = get_obs(0);
        check("mul.op_count", o.cnt, 16'd1);

        // Single-precision add from requester 1.
        req[0][1] = '{1'b1, 1'b0, 1'b1, 32'h40E00000, 32'h40200000};
        #1;
        o = get_obs(0);
        check("add.req1_ready", o.rdy1, 1'b1);
        tick();
        req[0][1].valid = 1'b0;
        tick(2);
        o = get_obs(0);
        check("add.rsp_id", o.rid, 1'b1);
        check("add.rsp_result", o.rres, 32'h41180000);
        tick();
        o = get_obs(0);
        check("add.op_count", o.cnt, 16'd2);

        // Contention: both requesters valid straight out of reset.
        rst[0] = 1'b1;
        acc_q0.delete();
        req[0][0] = '{1'b1, 1'b1, 1'b1, 32'h3F800000, 32'h40000000};
        req[0][1] = '{1'b1, 1'b0, 1'b0, 32'h00003C00, 32'h00004000};
        tick();
        rst[0] = 1'b0;
        tick(18);
        req[0][0].valid = 1'b0;
        req[0][1].valid = 1'b0;
        check("cont.accepts_ge4", acc_q0.size() >= 4, 1'b1);
        if (acc_q0.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("cont.id%0d", i), acc_q0[i] % 2, i % 2);
                if (i > 0) check($sformatf("cont.gap%0d", i), acc_q0[i] / 2 - acc_q0[i-1] / 2, 4);
            end
        end
        wait_idle(0, 10);

        // Backpressure: response held for 10 cycles while requester 0 stays valid.
        rsp_ready[0] = 1'b0;
        req[0][0] = '{1'b1, 1'b0, 1'b0, 32'h12345678, 32'h0BADF00D};
        #1;
        o = get_obs(0);
        check("bp.req0_ready", o.rdy0, 1'b1);
        tick(3);
        saved = get_obs(0);
        check("bp.rv", saved.rv, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            o = get_obs(0);
            check("bp.hold_rv", o.rv, 1'b1);
            check("bp.hold_ready", o.rdy0, 1'b0);
            check("bp.hold_result", o.rres, saved.rres);
            check("bp.hold_flags", o.rfl, saved.rfl);
        end
        rsp_ready[0] = 1'b1;
        #1;
        o = get_obs(0);
        check("bp.ready_in_resp", o.rdy0, 1'b0);
        tick();
        o = get_obs(0);
        check("bp.idle_busy", o.busy, 1'b0);
        check("bp.idle_ready", o.rdy0, 1'b1);
        check("bp.op_count", o.cnt, saved.cnt + 16'd1);
        tick();
        req[0][0].valid = 1'b0;
        o = get_obs(0);
        check("bp.reaccept_busy", o.busy, 1'b1);
        wait_idle(0, 10);

        // Reset one cycle after accept drops the operation.
        req[0][0] = '{1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h00000001};
        #1;
        o = get_obs(0);
        check("rst.req0_ready", o.rdy0, 1'b1);
        tick();
        req[0][0].valid = 1'b0;
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        o = get_obs(0);
        check("rst.busy", o.busy, 1'b0);
        check("rst.rv", o.rv, 1'b0);
        check("rst.fpu_a", o.fa, 32'h0);
        check("rst.op_count", o.cnt, 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            o = get_obs(0);
            check("rst.no_rsp", o.rv, 1'b0);
        end

        // LATENCY = 1, half-precision multiply.
        req[1][0] = '{1'b1, 1'b1, 1'b0, 32'h00004700, 32'h00004100};
        #1;
        o = get_obs(1);
        check("l1.req0_ready", o.rdy0, 1'b1);
        tick();
        req[1][0].valid = 1'b0;
        o = get_obs(1);
        check("l1.rv_after_e0", o.rv, 1'b0);
        tick();
        o = get_obs(1);
        check("l1.rv_after_e1", o.rv, 1'b1);
        check("l1.rsp_result", o.rres, 32'h00004C60);
        check("l1.rsp_id", o.rid, 1'b0);
        tick();
        o = get_obs(1);
        check("l1.op_count", o.cnt, 16'd1);

        // LATENCY = 1 throughput: accepts every LATENCY + 2 = 3 cycles.
        acc_q1.delete();
        req[1][1] = '{1'b1, 1'b0, 1'b1, 32'h40E00000, 32'h40200000};
        tick(10);
        req[1][1].valid = 1'b0;
        check("l1.accepts_ge3", acc_q1.size() >= 3, 1'b1);
        if (acc_q1.size() >= 3) begin
            for (int i = 1; i < 3; i++) begin
                check($sformatf("l1.gap%0d", i), acc_q1[i] / 2 - acc_q1[i-1] / 2, 3);
                check($sformatf("l1.id%0d", i), acc_q1[i] % 2, 1);
            end
        end
        wait_idle(1, 10);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Sequencer and two-way round-robin arbiter that shares one combinational FPU (add/mul, half/single) between two requesters. It accepts one operation at a time over a valid/ready handshake and registers the operands that drive the FPU. It holds them for a programmable number of settle cycles, then captures the FPU result and flags and returns them on a shared response channel tagged with the requester ID. It sits between the core's execute stage (requester 0), an auxiliary requester (requester 1) and the FPU instance.

## Interface
- LATENCY, 2, settle cycles from operand capture to result capture; legal range 1..15, anything else is an elaboration error.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- req0_op / req1_op  in  1  0 = add, 1 = mul (FPUControl encoding).
- req0_type / req1_type  in  1  0 = half, 1 = single (floatType encoding).
- req0_a, req0_b / req1_a, req1_b  in  32  operands.
- fpu_control  out  1  registered op to the FPU.
- fpu_float_type  out  1  registered type to the FPU.
- fpu_a, fpu_b  out  32  registered operands to the FPU.
- fpu_result  in  32  FPU Result.
- fpu_flags  in  4  FPU ALUFlags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the op.
- rsp_result  out  32  captured result.
- rsp_flags  out  4  captured flags.
- busy  out  1  high in every state except IDLE.
- op_count  out  16  completed responses; wraps 0xFFFF -> 0x0000.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE, arbitration:** the grant is computed combinationally from the valids and last_grant.
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - req*_ready = (state == IDLE) & grant*. Ready may depend on valid in the same cycle.
  - At most one ready is high per cycle.
- **IDLE, accept:** on the edge where the handshake completes:
  - capture op, type, a and b into the fpu_* registers;
  - set rsp_id to the granted ID and last_grant to the granted ID;
  - load cnt = LATENCY - 1 (4-bit) and go to EXEC.
- **EXEC:** fpu_* registers are held constant.
  - If cnt == 0: capture fpu_result into rsp_result and fpu_flags into rsp_flags, then go to RESP.
  - Otherwise decrement cnt.
  - req*_ready is low throughout.
- **RESP:** rsp_valid = 1, and rsp_id, rsp_result and rsp_flags are held stable.
  - On an edge with rsp_ready = 1: go to IDLE and increment op_count.
  - No new request is accepted in that same cycle.
- fpu_* registers keep their last values in IDLE and RESP. The FPU output is don't-care there.
- Requester inputs are sampled only on the accept edge. Later changes to operands or op have no effect on the in-flight operation.

## Timing
- **Reset state:** state = IDLE, last_grant = 1 (requester 0 wins the first contention).
  - All of these are 0: cnt, fpu_control, fpu_float_type, fpu_a, fpu_b, rsp_id, rsp_result, rsp_flags, op_count.
  - Therefore rsp_valid = 0, busy = 0, req*_ready = 0 during reset.
- **Latency:** with the accept edge as E0, results are captured at edge E0 + LATENCY. rsp_valid is high from that edge onward.
- **Throughput:** with rsp_ready tied high, one operation per LATENCY + 2 cycles. Accept edges are spaced LATENCY + 2 apart.
- **Contention:** two requesters both held valid alternate strictly 0, 1, 0, 1, …
- **Reset mid-operation** (EXEC or RESP): the in-flight op is dropped with no response and op_count is cleared. Reset overrides any simultaneous handshake.
- **RESP with rsp_ready low:** stays in RESP indefinitely and the outputs do not change.
- **LATENCY = 1:** cnt loads 0, so the result is captured on the first EXEC edge.

## Test plan
- **Single-precision multiply, LATENCY = 2:**
  - Stimulus: req0 op=1, type=1, a=0x40E00000, b=0x40200000.
  - Required: req0_ready high in the accept cycle; rsp_valid rises 2 edges after accept; rsp_id=0; rsp_result=0x418C0000; op_count=1.
- **Single-precision add, from requester 1:**
  - Stimulus: req1 op=0, type=1, same operands.
  - Required: rsp_id=1, rsp_result=0x41180000.
- **Contention:**
  - Stimulus: both valid continuously from reset, rsp_ready=1.
  - Required: accept order 0, 1, 0, 1; accept edges 4 cycles apart at LATENCY = 2.
- **Backpressure:**
  - Stimulus: rsp_ready low for 10 cycles in RESP while req0 is valid.
  - Required: rsp outputs stable; req0_ready stays 0; IDLE is entered on the rsp_ready edge; the next accept comes one cycle later.
- **Reset in EXEC:**
  - Stimulus: assert reset one cycle after accept.
  - Required: the next cycle shows IDLE, busy=0, rsp_valid never asserts, fpu_a=0, op_count=0.
- **LATENCY = 1, half-precision multiply:**
  - Stimulus: a=0x4700, b=0x4100, type=0.
  - Required: rsp_valid one edge after accept; rsp_result equals the FPU output for those operands, i.e. 0x00004C60.
